// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the ALU shift sequencer: opcode
//             constants, FSM state type and datapath width defaults.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Default datapath and shift-count widths
  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_SHAMT_W = 5;

  // ALU opcodes; 1001..1111 are undefined and follow the single-cycle path
  localparam logic [3:0] ADD_OP = 4'b0000;
  localparam logic [3:0] SUB_OP = 4'b0001;
  localparam logic [3:0] AND_OP = 4'b0010;
  localparam logic [3:0] OR_OP  = 4'b0011;
  localparam logic [3:0] XOR_OP = 4'b0100;
  localparam logic [3:0] NOR_OP = 4'b0101;
  localparam logic [3:0] SLA_OP = 4'b0110;
  localparam logic [3:0] SRA_OP = 4'b0111;
  localparam logic [3:0] SRL_OP = 4'b1000;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Shift opcodes are iterated one bit per cycle through the ALU
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == SLA_OP) || (op == SRA_OP) || (op == SRL_OP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_shift_sequencer
//  Purpose  : Accepts ALU commands, drives an external combinational ALU and
//             returns a registered result. Multi-bit shifts are performed as
//             repeated single-bit ALU shifts, one per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module alu_shift_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  // command side
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_opA,
  input  logic [DATA_W-1:0]  in_opB,
  input  logic [3:0]         in_op,
  input  logic [SHAMT_W-1:0] in_shamt,
  // external ALU
  output logic [DATA_W-1:0]  alu_operandA,
  output logic [DATA_W-1:0]  alu_operandB,
  output logic [3:0]         alu_op,
  output logic               alu_shift,
  input  logic [DATA_W-1:0]  alu_res,
  input  logic               alu_zero,
  input  logic               alu_carry,
  // result side
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_res,
  output logic               out_zero,
  output logic               out_carry
);

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    acc_q, acc_d;      // operand A, becomes running shift value
  logic [DATA_W-1:0]    opb_q, opb_d;
  logic [3:0]           op_q, op_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;      // remaining single-bit shifts
  logic [DATA_W-1:0]    res_q, res_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;

  logic                 accept;

  // Handshake: ready only when idle and not being reset
  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  // ALU drive comes straight from the latched command, so it cannot toggle
  // while idle or waiting for the result to be taken.
  assign alu_operandA = acc_q;
  assign alu_operandB = opb_q;
  assign alu_op       = op_q;
  assign alu_shift    = (state_q == SHIFT);

  assign out_res   = res_q;
  assign out_zero  = zero_q;
  assign out_carry = carry_q;

  // Next-state and datapath update for the command sequence
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d = in_opA;
          opb_d = in_opB;
          op_d  = in_op;
          if (is_shift_op(in_op)) begin
            cnt_d = in_shamt;
            if (in_shamt == '0) begin
              // Zero-distance shift: result is operand A, no ALU pass
              res_d   = in_opA;
              zero_d  = (in_opA == '0);
              carry_d = 1'b0;
              state_d = DONE;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            cnt_d   = '0;
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        // Single ALU pass; undefined opcodes land here too
        res_d   = alu_res;
        zero_d  = alu_zero;
        carry_d = alu_carry;
        state_d = DONE;
      end

      SHIFT: begin
        acc_d = alu_res;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          // Last bit position: shift-out carry is not reported
          res_d   = alu_res;
          zero_d  = alu_zero;
          carry_d = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_shift_sequencer
//  Purpose  : Self-checking bench for alu_shift_sequencer with a behavioural
//             external ALU and an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_shift_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_opA, in_opB;
  logic [3:0]  in_op;
  logic [4:0]  in_shamt;
  logic [31:0] alu_operandA, alu_operandB;
  logic [3:0]  alu_op;
  logic        alu_shift;
  logic [31:0] alu_res;
  logic        alu_zero, alu_carry;
  logic        out_valid, out_ready;
  logic [31:0] out_res;
  logic        out_zero, out_carry;
  logic [32:0] alu_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_shift_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opA(in_opA), .in_opB(in_opB), .in_op(in_op), .in_shamt(in_shamt),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_op(alu_op), .alu_shift(alu_shift),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_zero(out_zero), .out_carry(out_carry)
  );

  // Behavioural external ALU: one-bit shifts when alu_shift is set
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_sum   = '0;
    if (alu_shift) begin
      case (alu_op)
        SLA_OP: begin alu_res = {alu_operandA[30:0], 1'b0}; alu_carry = alu_operandA[31]; end
        SRA_OP: begin alu_res = {alu_operandA[31], alu_operandA[31:1]}; alu_carry = alu_operandA[0]; end
        SRL_OP: begin alu_res = {1'b0, alu_operandA[31:1]}; alu_carry = alu_operandA[0]; end
        default: alu_res = '0;
      endcase
    end else begin
      case (alu_op)
        ADD_OP: begin
          alu_sum = {1'b0, alu_operandA} + {1'b0, alu_operandB};
          alu_res = alu_sum[31:0]; alu_carry = alu_sum[32];
        end
        SUB_OP: begin
          alu_sum = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
          alu_res = alu_sum[31:0]; alu_carry = alu_sum[32];
        end
        AND_OP: alu_res = alu_operandA & alu_operandB;
        OR_OP:  alu_res = alu_operandA | alu_operandB;
        XOR_OP: alu_res = alu_operandA ^ alu_operandB;
        NOR_OP: alu_res = ~(alu_operandA | alu_operandB);
        default: alu_res = '0;
      endcase
    end
    alu_zero = (alu_res == '0);
  end

  // Reference model: whole-command result and cycles from accept to out_valid
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic z,
                                output logic c, output int lat);
    logic [32:0] w;
    c   = 1'b0;
    lat = 2;
    case (op)
      ADD_OP: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; end
      SUB_OP: begin r = a - b; c = (a >= b); end
      AND_OP: r = a & b;
      OR_OP:  r = a | b;
      XOR_OP: r = a ^ b;
      NOR_OP: r = ~(a | b);
      SLA_OP: begin r = a << sh; lat = 1 + int'(sh); end
      SRA_OP: begin r = $unsigned($signed(a) >>> sh); lat = 1 + int'(sh); end
      SRL_OP: begin r = a >> sh; lat = 1 + int'(sh); end
      default: r = '0;
    endcase
    z = (r == '0);
  endfunction

  // Issue one command (caller is at a negedge with the DUT idle), wait for
  // the result, hold out_ready low for 'stall' cycles, then release it.
  // Returns at the negedge of the first idle cycle.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input int stall, input string name);
    logic [31:0] er;
    logic        ez, ec;
    int          elat, lat;
    logic        busy_ready;
    logic [31:0] hold_a;
    model(op, a, b, sh, er, ez, ec, elat);
    busy_ready = 1'b0;

    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready: got %b expected 1", name, in_ready);
    end
    in_valid = 1'b1; in_op = op; in_opA = a; in_opB = b; in_shamt = sh; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_opA = $urandom; in_opB = $urandom; in_op = 4'($urandom); in_shamt = 5'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) busy_ready = 1'b1;
      @(negedge clk);
      lat++;
    end

    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s timeout: out_valid got %b expected 1 within 100 cycles", name, out_valid);
    end
    checks++;
    if (lat != elat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
    end
    checks++;
    if (out_res !== er || out_zero !== ez || out_carry !== ec) begin
      errors++;
      $display("FAIL %s result: got res=%h z=%b c=%b expected res=%h z=%b c=%b",
               name, out_res, out_zero, out_carry, er, ez, ec);
    end
    checks++;
    if (busy_ready || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s busy_ready: got in_ready high while busy, expected 0", name);
    end

    hold_a = alu_operandA;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_res !== er || out_zero !== ez ||
          out_carry !== ec || alu_operandA !== hold_a || alu_shift !== 1'b0) begin
        errors++;
        $display("FAIL %s stall%0d: got v=%b rdy=%b res=%h aluA=%h sh=%b expected v=1 rdy=0 res=%h aluA=%h sh=0",
                 name, i, out_valid, in_ready, out_res, alu_operandA, alu_shift, er, hold_a);
      end
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s release: got v=%b rdy=%b expected v=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opA = '0; in_opB = '0; in_op = '0; in_shamt = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_res !== '0 || out_zero !== 1'b0 ||
        out_carry !== 1'b0 || alu_operandA !== '0 || alu_operandB !== '0 || alu_op !== '0 ||
        alu_shift !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b res=%h z=%b c=%b aluA=%h aluB=%h op=%h sh=%b expected all 0",
               in_ready, out_valid, out_res, out_zero, out_carry, alu_operandA, alu_operandB, alu_op, alu_shift);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: in_ready got %b expected 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_cmd(ADD_OP, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0, "add_wrap");
    run_cmd(SLA_OP, 32'h0000_0001, 32'h0, 5'd31, 0, "sla31");
    run_cmd(SRA_OP, 32'h8000_0000, 32'h0, 5'd4, 0, "sra4");
    run_cmd(SRL_OP, 32'h8000_0000, 32'h0, 5'd4, 0, "srl4");
    run_cmd(SRL_OP, 32'h0000_1234, 32'h0, 5'd0, 0, "srl0");
    run_cmd(4'b1111, 32'h5, 32'h3, 5'd0, 0, "undef_op");
    run_cmd(SLA_OP, 32'hC000_0001, 32'h0, 5'd1, 0, "sla_carry_out");
  endtask

  task automatic test_backpressure();
    run_cmd(SUB_OP, 32'h10, 32'h20, 5'd0, 5, "stall5");
    run_cmd(XOR_OP, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd0, 0, "after_stall");
  endtask

  task automatic test_back_to_back();
    run_cmd(AND_OP, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 0, "b2b_and");
    run_cmd(SRA_OP, 32'h7000_0000, 32'h0, 5'd3, 0, "b2b_sra");
    run_cmd(NOR_OP, 32'h0, 32'h0, 5'd7, 0, "b2b_nor");
    run_cmd(OR_OP, 32'h0, 32'h0, 5'd0, 0, "b2b_or_zero");
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [4:0] sh;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_cmd(op, $urandom, $urandom, sh, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    seen = 1'b0;
    in_valid = 1'b1; in_op = SLA_OP; in_opA = 32'h0000_0003; in_opB = 32'h0; in_shamt = 5'd10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_res !== '0 || in_ready !== 1'b0 || alu_shift !== 1'b0 ||
        alu_operandA !== '0) begin
      errors++;
      $display("FAIL abort_in_reset: got v=%b res=%h rdy=%b sh=%b aluA=%h expected 0 0 0 0 0",
               out_valid, out_res, in_ready, alu_shift, alu_operandA);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_ready: in_ready got %b expected 1", in_ready);
    end
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0 || out_res !== '0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL abort_no_result: got out_valid/out_res activity expected none");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_shift_sequencer.md
ALU_SHIFT_SEQUENCER -- requirements
Module: alu_shift_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: operand/result width; SHALL match the ALU datapath.
REQ-002 Parameter SHAMT_W, default 5: shift-count width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 in_valid  in  1  upstream command valid.
REQ-006 in_ready  out  1  sequencer can accept a command.
REQ-007 in_opA / in_opB  in  DATA_W each  command operands.
REQ-008 in_op  in  4  ALU opcode (ADD 0000 … SRL 1000).
REQ-009 in_shamt  in  SHAMT_W  shift count; used only for opcodes 0110/0111/1000.
REQ-010 alu_operandA / alu_operandB  out  DATA_W each  drive to the ALU.
REQ-011 alu_op  out  4; alu_shift  out  1  drive to the ALU.
REQ-012 alu_res  in  DATA_W; alu_zero  in  1; alu_carry  in  1  combinational ALU return.
REQ-013 out_valid  out  1; out_ready  in  1  result handshake.
REQ-014 out_res  out  DATA_W; out_zero  out  1; out_carry  out  1  registered result and flags.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, SHIFT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE and rst=0; command accepted on in_valid & in_ready.
REQ-017 On accept: latch opA into accumulator, opB, op, shamt; next state: shift opcode with shamt=0 -> DONE; shift opcode with shamt>0 -> SHIFT, counter=shamt; else -> EXEC.
REQ-018 shamt=0 shift: bypass ALU; out_res=opA, out_zero=(opA==0), out_carry=0; out_valid at accept+1.
REQ-019 EXEC: drive accumulator/opB/op with alu_shift=0 for one cycle; capture alu_res/zero/carry into outputs; -> DONE; out_valid at accept+2.
REQ-020 SHIFT: alu_shift=1 each cycle; accumulator <= alu_res; counter decrements; when counter==1, capture result and alu_zero, force out_carry=0, -> DONE; out_valid at accept+1+shamt.
REQ-021 Undefined opcodes (1001–1111) SHALL take the EXEC path; result is whatever the ALU returns (0, zero=1).
REQ-022 DONE: out_valid=1; out_res/out_zero/out_carry SHALL stay stable until out_ready=1, then -> IDLE next cycle.
REQ-023 No command SHALL be accepted in the cycle DONE completes; next accept earliest one cycle after.
REQ-024 In IDLE/DONE, ALU drive outputs SHALL hold latched values (no toggling).
REQ-025 Counter SHALL be SHAMT_W bits; shamt=31 SHALL complete in exactly 31 SHIFT cycles without wrap.

Reset
REQ-026 While rst=1: state IDLE, in_ready=0, out_valid=0, out_res=0, out_zero=0, out_carry=0, accumulator/counter=0, alu_* outputs=0.
REQ-027 rst asserted in any state SHALL abandon the operation; no out_valid SHALL be produced for it.
REQ-028 in_ready SHALL return to 1 the first cycle after rst deasserts.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode constants (ADD_OP … SRL_OP), FSM state type and DATA_W default.
REQ-030 No sub-module; the ALU stays external, connected at the parent level; counter and FSM inline.

Verification
REQ-031 ADD 0xFFFFFFFF + 0x00000001 -> out_res 0x00000000, zero 1, carry 1, out_valid 2 cycles after accept.
REQ-032 SLA opA=0x00000001 shamt=31 -> out_res 0x80000000, carry 0, out_valid 32 cycles after accept.
REQ-033 SRA opA=0x80000000 shamt=4 -> 0xF8000000; SRL same operands -> 0x08000000; SRL shamt=0 opA=0x1234 -> 0x1234 at accept+1.
REQ-034 Back-pressure: out_ready low 5 cycles in DONE -> outputs stable, in_ready 0; out_ready high -> IDLE, next command accepted one cycle later.
REQ-035 rst pulsed during SHIFT (SLA shamt=10, cycle 4) -> out_valid never asserts, outputs 0, in_ready 1 the cycle after rst falls.
REQ-036 Opcode 1111 opA=0x5 opB=0x3 -> out_res 0, zero 1, carry 0 at accept+2.
